// File: rtl/perf_counter_unit_pkg.sv
// Shared definitions for the performance counter unit and its CPI engine.
// Holds the CPI FSM encoding, Q7.8 format constants and the CPI saturation value.
package perf_counter_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } cpi_state_t;

    localparam int          CPI_FRAC_BITS = 8;
    localparam int          CPI_W         = 16;
    localparam logic [15:0] CPI_SAT       = 16'hFFFF;

endpackage

// File: rtl/perf_counter_unit_divider.sv
// Restoring divider producing one quotient bit per cycle, DIVIDEND_W cycles per result.
// start is taken only when idle; done is high during the final iteration, quotient is final the cycle after.
module seq_divider #(
    parameter int DIVIDEND_W = 40,
    parameter int DIVISOR_W  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  abort,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient
);

    localparam int ITER_W = $clog2(DIVIDEND_W + 1);

    logic [DIVISOR_W-1:0] rem;
    logic [DIVISOR_W-1:0] den;
    logic [ITER_W-1:0]    iter;
    logic [DIVISOR_W:0]   trial;
    logic [DIVISOR_W:0]   diff;

    // The dividend shifts out of the quotient register MSB-first as quotient bits shift in.
    assign trial = {rem, quotient[DIVIDEND_W-1]};
    assign diff  = trial - {1'b0, den};
    assign done  = busy && (iter == ITER_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= 1'b0;
            iter     <= '0;
            rem      <= '0;
            den      <= '0;
            quotient <= '0;
        end else if (abort) begin
            busy     <= 1'b0;
            iter     <= '0;
            rem      <= '0;
            quotient <= '0;
        end else if (start && !busy) begin
            busy     <= 1'b1;
            iter     <= ITER_W'(DIVIDEND_W);
            rem      <= '0;
            den      <= divisor;
            quotient <= dividend;
        end else if (busy) begin
            if (!diff[DIVISOR_W]) begin
                rem      <= diff[DIVISOR_W-1:0];
                quotient <= {quotient[DIVIDEND_W-2:0], 1'b1};
            end else begin
                rem      <= trial[DIVISOR_W-1:0];
                quotient <= {quotient[DIVIDEND_W-2:0], 1'b0};
            end
            iter <= iter - ITER_W'(1);
            if (iter == ITER_W'(1))
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/perf_counter_unit.sv
// Saturating pipeline event counters plus a free-running CPI engine (Q7.8, refresh every CNT_W+10 cycles).
// Counter outputs update on the edge that samples the event; no backpressure.
module perf_counter_unit
    import perf_counter_unit_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int OUT_W = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             count_en,
    input  logic             clear,
    input  logic             stall_in,
    input  logic             retire_in,
    input  logic             arith_in,
    input  logic             mem_in,
    output logic [OUT_W-1:0] stall_count_out,
    output logic [OUT_W-1:0] cycles_per_instruction_q78_out,
    output logic [OUT_W-1:0] arith_count_out,
    output logic [OUT_W-1:0] mem_access_count_out,
    output logic             cpi_valid
);

    localparam int DIV_W = CNT_W + CPI_FRAC_BITS;

    logic [CNT_W-1:0] cycle_cnt, retire_cnt, stall_cnt, arith_cnt, mem_cnt;
    logic [CNT_W-1:0] retire_snap;
    logic [CPI_W-1:0] cpi_q;
    cpi_state_t       state;

    logic             div_busy, div_done;
    logic [DIV_W-1:0] div_quo;
    logic             over_range;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic ev);
        return (ev && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
            stall_cnt  <= '0;
            arith_cnt  <= '0;
            mem_cnt    <= '0;
        end else if (count_en) begin
            cycle_cnt  <= bump(cycle_cnt, 1'b1);
            retire_cnt <= bump(retire_cnt, retire_in);
            stall_cnt  <= bump(stall_cnt, stall_in);
            arith_cnt  <= bump(arith_cnt, arith_in && retire_in);
            mem_cnt    <= bump(mem_cnt, mem_in);
        end
    end

    // The divider latches the live counters in IDLE, i.e. the values before this cycle's increment.
    seq_divider #(
        .DIVIDEND_W (DIV_W),
        .DIVISOR_W  (CNT_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .abort    (clear),
        .start    ((state == IDLE) && !clear),
        .dividend ({cycle_cnt, {CPI_FRAC_BITS{1'b0}}}),
        .divisor  (retire_cnt),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    assign over_range = (retire_snap == '0) || (|div_quo[DIV_W-1:CPI_W]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            state       <= IDLE;
            retire_snap <= '0;
            cpi_q       <= '0;
            cpi_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    retire_snap <= retire_cnt;
                    state       <= DIV;
                end
                // An idle divider while in DIV can only mean it was lost; move on rather than hang.
                DIV: if (div_done || !div_busy) state <= DONE;
                DONE: begin
                    cpi_q     <= over_range ? CPI_SAT : div_quo[CPI_W-1:0];
                    cpi_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stall_count_out                = OUT_W'(stall_cnt);
    assign arith_count_out                = OUT_W'(arith_cnt);
    assign mem_access_count_out           = OUT_W'(mem_cnt);
    assign cycles_per_instruction_q78_out = OUT_W'(cpi_q);

endmodule

// File: tb/tb_perf_counter_unit.sv
// Directed bench for perf_counter_unit: table of counting bursts plus hand-written reset/clear/saturation sequences.
module tb_perf_counter_unit;

    localparam int CNT_W = 32;
    localparam int OUT_W = 256;

    logic clk = 1'b0;
    logic reset, count_en, clear, stall_in, retire_in, arith_in, mem_in;
    logic [OUT_W-1:0] stall_count_out, cpi_out, arith_count_out, mem_count_out;
    logic cpi_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          n;
        logic [15:0] stall, retire, arith, mem;
        logic [15:0] exp_stall, exp_arith, exp_mem, exp_cpi;
    } vec_t;

    vec_t vecs[10];

    perf_counter_unit #(.CNT_W(CNT_W), .OUT_W(OUT_W)) dut (
        .clk                            (clk),
        .reset                          (reset),
        .count_en                       (count_en),
        .clear                          (clear),
        .stall_in                       (stall_in),
        .retire_in                      (retire_in),
        .arith_in                       (arith_in),
        .mem_in                         (mem_in),
        .stall_count_out                (stall_count_out),
        .cycles_per_instruction_q78_out (cpi_out),
        .arith_count_out                (arith_count_out),
        .mem_access_count_out           (mem_count_out),
        .cpi_valid                      (cpi_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic inputs_low();
        count_en = 1'b0; stall_in = 1'b0; retire_in = 1'b0; arith_in = 1'b0; mem_in = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic run_pattern(input vec_t v);
        count_en = 1'b1;
        for (int i = 0; i < v.n; i++) begin
            stall_in  = v.stall[i];
            retire_in = v.retire[i];
            arith_in  = v.arith[i];
            mem_in    = v.mem[i];
            tick();
        end
        inputs_low();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, stall_count_out, '0);
        check({tag, "_arith"}, arith_count_out, '0);
        check({tag, "_mem"},   mem_count_out,   '0);
        check({tag, "_cpi"},   cpi_out,         '0);
        check({tag, "_valid"}, OUT_W'(cpi_valid), '0);
    endtask

    initial begin
        //             n   stall    retire   arith    mem      e_stl e_ari e_mem e_cpi
        vecs[0] = '{10, 16'h0000, 16'h03FF, 16'h0000, 16'h0000, 16'd0,  16'd0, 16'd0,  16'h0100};
        vecs[1] = '{10, 16'h03FF, 16'h0049, 16'h0009, 16'h0001, 16'd10, 16'd2, 16'd1,  16'h0355};
        vecs[2] = '{12, 16'h0003, 16'h0FFF, 16'hF0F0, 16'h0555, 16'd2,  16'd4, 16'd6,  16'h0100};
        vecs[3] = '{16, 16'h00FF, 16'h8001, 16'hFFFF, 16'hFFFF, 16'd8,  16'd2, 16'd16, 16'h0800};
        vecs[4] = '{9,  16'h0000, 16'h0007, 16'h01F8, 16'h0000, 16'd0,  16'd0, 16'd0,  16'h0300};
        vecs[5] = '{7,  16'h0040, 16'h0003, 16'h0002, 16'h007F, 16'd1,  16'd1, 16'd7,  16'h0380};
        vecs[6] = '{1,  16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'd0,  16'd0, 16'd0,  16'h0100};
        vecs[7] = '{16, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'd16, 16'd0, 16'd0,  16'hFFFF};
        vecs[8] = '{13, 16'h0000, 16'h1000, 16'h1000, 16'h1555, 16'd0,  16'd1, 16'd7,  16'h0D00};
        vecs[9] = '{11, 16'h0000, 16'h0007, 16'h0000, 16'h0000, 16'd0,  16'd0, 16'd0,  16'h03AA};

        reset = 1'b1;
        clear = 1'b0;
        inputs_low();
        repeat (2) tick();
        check_all_zero("reset");
        reset = 1'b0;

        // Reset landing mid-division, then the first refresh timing.
        count_en = 1'b1; retire_in = 1'b1;
        repeat (62) tick();
        check("pre_reset_valid", OUT_W'(cpi_valid), OUT_W'(1'b1));
        #3 reset = 1'b1;
        #1 check_all_zero("mid_div_reset");
        tick();
        reset = 1'b0;
        repeat (CNT_W + 9) tick();
        check("post_reset_valid_early", OUT_W'(cpi_valid), '0);
        tick();
        check("post_reset_valid", OUT_W'(cpi_valid), OUT_W'(1'b1));
        check("post_reset_cpi", cpi_out, OUT_W'(16'hFFFF));
        inputs_low();

        for (int k = 0; k < 10; k++) begin
            do_clear();
            run_pattern(vecs[k]);
            repeat (100) tick();
            check($sformatf("vec%0d_stall", k), stall_count_out, OUT_W'(vecs[k].exp_stall));
            check($sformatf("vec%0d_arith", k), arith_count_out, OUT_W'(vecs[k].exp_arith));
            check($sformatf("vec%0d_mem", k),   mem_count_out,   OUT_W'(vecs[k].exp_mem));
            check($sformatf("vec%0d_cpi", k),   cpi_out,         OUT_W'(vecs[k].exp_cpi));
            check($sformatf("vec%0d_valid", k), OUT_W'(cpi_valid), OUT_W'(1'b1));
        end

        // Steady one-retire-per-cycle stream.
        do_clear();
        count_en = 1'b1; retire_in = 1'b1;
        repeat (200) tick();
        check("stream_cpi", cpi_out, OUT_W'(16'h0100));
        check("stream_valid", OUT_W'(cpi_valid), OUT_W'(1'b1));
        check("stream_arith", arith_count_out, '0);
        check("stream_mem", mem_count_out, '0);
        check("stream_stall", stall_count_out, '0);
        inputs_low();

        // Stall held high across the disabled window must not count.
        do_clear();
        stall_in = 1'b1; count_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            retire_in = (i < 4);
            tick();
        end
        count_en = 1'b0; retire_in = 1'b0;
        repeat (100) tick();
        check("gated_cpi", cpi_out, OUT_W'(16'h0280));
        check("gated_stall", stall_count_out, OUT_W'(10));
        inputs_low();

        // Quotient just below and just above the 16-bit range.
        for (int k = 0; k < 2; k++) begin
            do_clear();
            count_en = 1'b1;
            for (int i = 0; i < 255 + k; i++) begin
                retire_in = (i == 0);
                tick();
            end
            inputs_low();
            repeat (100) tick();
            check($sformatf("range%0d_cpi", k), cpi_out, (k == 0) ? OUT_W'(16'hFF00) : OUT_W'(16'hFFFF));
        end

        // No retires at all: divide-by-zero saturates.
        do_clear();
        check("zero_ret_valid_clear", OUT_W'(cpi_valid), '0);
        count_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (cpi_valid) break;
            tick();
        end
        check("zero_ret_valid", OUT_W'(cpi_valid), OUT_W'(1'b1));
        check("zero_ret_cpi", cpi_out, OUT_W'(16'hFFFF));
        inputs_low();

        // Counter saturation from a preloaded value.
        do_clear();
        force dut.stall_cnt = 32'hFFFF_FFFE;
        tick();
        release dut.stall_cnt;
        count_en = 1'b1; stall_in = 1'b1;
        repeat (3) tick();
        inputs_low();
        check("stall_saturate", stall_count_out, OUT_W'(32'hFFFF_FFFF));

        // Clear colliding with a memory event mid-division.
        do_clear();
        count_en = 1'b1; retire_in = 1'b1; mem_in = 1'b1;
        repeat (60) tick();
        check("pre_clear_mem", mem_count_out, OUT_W'(60));
        check("pre_clear_cpi", cpi_out, OUT_W'(16'hFFFF));
        check("pre_clear_valid", OUT_W'(cpi_valid), OUT_W'(1'b1));
        do_clear();
        check("clear_mem", mem_count_out, '0);
        check("clear_cpi", cpi_out, '0);
        check("clear_valid", OUT_W'(cpi_valid), '0);
        repeat (CNT_W + 9) tick();
        check("clear_restart_valid_early", OUT_W'(cpi_valid), '0);
        tick();
        check("clear_restart_valid", OUT_W'(cpi_valid), OUT_W'(1'b1));
        check("clear_restart_cpi", cpi_out, OUT_W'(16'hFFFF));
        check("clear_restart_mem", mem_count_out, OUT_W'(CNT_W + 10));
        inputs_low();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
